xyolo_mac_array: RTL and testbench

//  Next-gen YOLO conv datapath: N_MACS parallel signed MACs, pipelined adder tree, multi-beat accumulator.

---
 rtl/xyolo_mac_array.sv | 199 +++++++++++++++++++
 tb/tb_xyolo_mac_array.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/xyolo_mac_array.sv
// YOLO conv datapath: N_MACS signed MACs, registered adder tree, multi-beat accumulator and
// post stage (bias, shift, leaky ReLU, bypass, max-pool). Define XYOLO_SAT_EN for saturating narrowing.
module xyolo_mac_array #(
   parameter int DATAPATH_W = 16,
   parameter int N_MACS     = 4,
   parameter int SHIFT_W    = 6,
   parameter int MP_W       = 3,
   parameter int ACC_GUARD  = 8,
   localparam int LANE_W    = (N_MACS > 1) ? $clog2(N_MACS) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic                         in_last,
   input  logic [N_MACS*DATAPATH_W-1:0] in_pixel,
   input  logic [N_MACS*DATAPATH_W-1:0] in_weight,
   input  logic [DATAPATH_W-1:0]        in_bias,
   input  logic                         cfg_bias,
   input  logic                         cfg_leaky,
   input  logic                         cfg_bypass,
   input  logic [LANE_W-1:0]            cfg_lane,
   input  logic                         cfg_maxpool,
   input  logic [MP_W-1:0]              cfg_mp_len,
   input  logic [SHIFT_W-1:0]           cfg_shift,
   output logic                         out_valid,
   output logic [DATAPATH_W-1:0]        out_data,
   output logic                         busy
);

   localparam int DW    = DATAPATH_W;
   localparam int L     = $clog2(N_MACS);
   localparam int PW    = 2 * DW;
   localparam int ACC_W = PW + L + ACC_GUARD;

   // Stream contract: a beat is taken on every cycle with in_valid=1; there is no ready and no stall.
   typedef struct packed {
      logic          valid;
      logic          first;
      logic          last;
      logic [DW-1:0] byp;
      logic [DW-1:0] bias;
   } meta_t;

   logic                 first_q;
   meta_t                s0_meta;
   logic [N_MACS*DW-1:0] s0_pix;
   logic [N_MACS*DW-1:0] s0_wgt;
   logic [DW-1:0]        byp_sel;

   // Lane 0 is the fallback for any lane index outside the array.
   always_comb begin
      byp_sel = in_pixel[DW-1:0];
      for (int k = 1; k < N_MACS; k++) begin
         if (int'(cfg_lane) == k) byp_sel = in_pixel[k*DW +: DW];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         first_q       <= 1'b1;
         s0_meta.valid <= 1'b0;
      end else begin
         s0_meta.valid <= in_valid;
         if (in_valid) begin
            first_q       <= in_last;
            s0_meta.first <= first_q;
            s0_meta.last  <= in_last;
            s0_meta.byp   <= byp_sel;
            s0_meta.bias  <= in_bias;
            s0_pix        <= in_pixel;
            s0_wgt        <= in_weight;
         end
      end
   end

   // meta[k] rides alongside tree level k (level 0 = products).
   meta_t meta [L+1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= L; k++) meta[k].valid <= 1'b0;
      end else begin
         meta[0] <= s0_meta;
         for (int k = 1; k <= L; k++) meta[k] <= meta[k-1];
      end
   end

   for (genvar j = 0; j <= L; j++) begin : g_lvl
      localparam int LW  = PW + j;
      localparam int CNT = N_MACS >> j;
      logic signed [LW-1:0] sum [CNT];
      if (j == 0) begin : g_mul
         always_ff @(posedge clk) begin
            for (int i = 0; i < CNT; i++)
               sum[i] <= PW'($signed(s0_pix[i*DW +: DW])) * PW'($signed(s0_wgt[i*DW +: DW]));
         end
      end else begin : g_add
         always_ff @(posedge clk) begin
            for (int i = 0; i < CNT; i++)
               sum[i] <= LW'(g_lvl[j-1].sum[2*i]) + LW'(g_lvl[j-1].sum[2*i+1]);
         end
      end
   end

   meta_t                    mt;
   logic signed [ACC_W-1:0]  tree_ext;
   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [ACC_W-1:0]  acc_base;
   logic signed [ACC_W-1:0]  acc;
   logic                     acc_fire;
   logic signed [DW-1:0]     acc_byp;

   assign mt       = meta[L];
   assign tree_ext = ACC_W'(g_lvl[L].sum[0]);

   always_comb begin
      bias_ext = {{(ACC_W-DW){mt.bias[DW-1]}}, mt.bias};
      acc_base = acc;
      if (mt.first) acc_base = cfg_bias ? (bias_ext <<< cfg_shift) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         acc_fire <= 1'b0;
         acc_byp  <= '0;
      end else begin
         acc_fire <= mt.valid & mt.last;
         if (mt.valid) begin
            acc     <= acc_base + tree_ext;
            acc_byp <= mt.byp;
         end
      end
   end

   logic signed [DW-1:0] narrowed;
   logic signed [DW-1:0] post;

`ifdef XYOLO_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
   logic signed [ACC_W-1:0] shifted;

   always_comb begin
      shifted = acc >>> cfg_shift;
      if (shifted > SAT_MAX)      narrowed = {1'b0, {(DW-1){1'b1}}};
      else if (shifted < SAT_MIN) narrowed = {1'b1, {(DW-1){1'b0}}};
      else                        narrowed = shifted[DW-1:0];
   end
`else
   assign narrowed = DW'(acc >>> cfg_shift);
`endif

   always_comb begin
      post = narrowed;
      if (cfg_leaky && narrowed[DW-1]) post = narrowed >>> 3;
      if (cfg_bypass) post = acc_byp;
   end

   logic [MP_W-1:0]      mp_cnt;
   logic signed [DW-1:0] mp_max;
   logic signed [DW-1:0] mp_cand;

   // Strict '>' keeps the earlier value on ties; the first result of a window always loads.
   assign mp_cand = ((mp_cnt == '0) || (post > mp_max)) ? post : mp_max;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         mp_max    <= '0;
         mp_cnt    <= '0;
      end else begin
         out_valid <= 1'b0;
         if (acc_fire) begin
            if (!cfg_maxpool) begin
               out_valid <= 1'b1;
               out_data  <= post;
               mp_cnt    <= '0;
            end else begin
               mp_max <= mp_cand;
               if (mp_cnt == cfg_mp_len) begin
                  out_valid <= 1'b1;
                  out_data  <= mp_cand;
                  mp_cnt    <= '0;
               end else begin
                  mp_cnt <= mp_cnt + MP_W'(1);
               end
            end
         end
      end
   end

   always_comb begin
      busy = s0_meta.valid | ~first_q | acc_fire | (mp_cnt != '0);
      for (int k = 0; k <= L; k++) busy = busy | meta[k].valid;
   end

endmodule

// File: tb/tb_xyolo_mac_array.sv
// Directed bench for xyolo_mac_array (DATAPATH_W=16, N_MACS=4): scoreboard queue of hand-computed results.
module tb_xyolo_mac_array;

   localparam int DW = 16;
   localparam int N  = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_last;
   logic [N*DW-1:0] in_pixel;
   logic [N*DW-1:0] in_weight;
   logic [DW-1:0]   in_bias;
   logic            cfg_bias;
   logic            cfg_leaky;
   logic            cfg_bypass;
   logic [1:0]      cfg_lane;
   logic            cfg_maxpool;
   logic [2:0]      cfg_mp_len;
   logic [5:0]      cfg_shift;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            busy;

   xyolo_mac_array dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
      .in_pixel(in_pixel), .in_weight(in_weight), .in_bias(in_bias),
      .cfg_bias(cfg_bias), .cfg_leaky(cfg_leaky), .cfg_bypass(cfg_bypass),
      .cfg_lane(cfg_lane), .cfg_maxpool(cfg_maxpool), .cfg_mp_len(cfg_mp_len),
      .cfg_shift(cfg_shift), .out_valid(out_valid), .out_data(out_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int              checks   = 0;
   int              failures = 0;
   string           cur_test = "reset";
   logic [DW-1:0]   exp_q[$];
   int              lat;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Scoreboard: every out_valid pops one expected result.
   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check({cur_test, "_spurious_out_valid"}, int'(out_valid), 0);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            check({cur_test, "_out_data"}, $signed(out_data), $signed(e));
         end
      end
   end

   task automatic push(input int v);
      exp_q.push_back(DW'(v));
   endtask

   task automatic set_cfg(input bit b, input bit lk, input bit byp, input int lane,
                          input bit mp, input int mp_len, input int sh);
      cfg_bias    = b;
      cfg_leaky   = lk;
      cfg_bypass  = byp;
      cfg_lane    = 2'(lane);
      cfg_maxpool = mp;
      cfg_mp_len  = 3'(mp_len);
      cfg_shift   = 6'(sh);
   endtask

   task automatic beat(input bit last, input int p0, input int p1, input int p2, input int p3,
                       input int w0, input int w1, input int w2, input int w3, input int bias);
      @(negedge clk);
      in_valid  = 1'b1;
      in_last   = last;
      in_pixel  = {16'(p3), 16'(p2), 16'(p1), 16'(p0)};
      in_weight = {16'(w3), 16'(w2), 16'(w1), 16'(w0)};
      in_bias   = 16'(bias);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   // Counts clock edges from the last applied beat to the first out_valid (bounded).
   task automatic wait_out(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid && cycles < 0) cycles = i;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      in_pixel = '0; in_weight = '0; in_bias = '0;
      set_cfg(0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_data", $signed(out_data), 0);
      check("reset_busy", int'(busy), 0);
      rst = 1'b0;

      // Single-beat dot product and its latency.
      cur_test = "t1_dot";
      push(70);
      beat(1, 1, 2, 3, 4, 5, 6, 7, 8, 0);
      wait_out(lat);
      check("t1_latency", lat, 6);

      // Two beats with bias; bias on the second beat must be ignored.
      cur_test = "t2_bias";
      set_cfg(1, 0, 0, 0, 0, 0, 8);
      push(2051);
      beat(0, 256, 256, 256, 256, 256, 256, 256, 256, 3);
      beat(1, 256, 256, 256, 256, 256, 256, 256, 256, 100);
      check("t2_busy_mid", int'(busy), 1);
      idle(12);
      check("t2_busy_idle", int'(busy), 0);

      // Leaky ReLU, arithmetic shift floors toward minus infinity.
      cur_test = "t3_leaky";
      set_cfg(0, 1, 0, 0, 0, 0, 0);
      push(-10); push(-11); push(80);
      beat(1, -80, 0, 0, 0, 1, 0, 0, 0, 0);
      beat(1, -81, 0, 0, 0, 1, 0, 0, 0, 0);
      beat(1, 80, 0, 0, 0, 1, 0, 0, 0, 0);
      idle(12);

      cur_test = "t3_shift";
      set_cfg(0, 0, 0, 0, 0, 0, 2);
      push(-21); push(20);
      beat(1, -81, 0, 0, 0, 1, 0, 0, 0, 0);
      beat(1, 81, 0, 0, 0, 1, 0, 0, 0, 0);
      idle(12);

      // Bypass returns the raw pixel lane, ignoring shift and leaky.
      cur_test = "t3_bypass";
      set_cfg(0, 1, 1, 2, 0, 0, 5);
      push(-33);
      beat(1, 11, 22, -33, 44, 1, 1, 1, 1, 0);
      idle(12);

      // Max-pool windows of four, including an all-negative window.
      cur_test = "t4_maxpool";
      set_cfg(0, 0, 0, 0, 1, 3, 0);
      push(12);
      beat(1, 5, 0, 0, 0, 1, 0, 0, 0, 0);
      beat(1, -3, 0, 0, 0, 1, 0, 0, 0, 0);
      beat(1, 12, 0, 0, 0, 1, 0, 0, 0, 0);
      beat(1, 7, 0, 0, 0, 1, 0, 0, 0, 0);
      push(-2);
      beat(1, -5, 0, 0, 0, 1, 0, 0, 0, 0);
      beat(1, -2, 0, 0, 0, 1, 0, 0, 0, 0);
      beat(1, -9, 0, 0, 0, 1, 0, 0, 0, 0);
      beat(1, -7, 0, 0, 0, 1, 0, 0, 0, 0);
      idle(12);

      // A partly filled window keeps busy high until reset discards it.
      cur_test = "t4_open_window";
      beat(1, 3, 0, 0, 0, 1, 0, 0, 0, 0);
      idle(12);
      check("t4_busy_window_open", int'(busy), 1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("t4_busy_after_rst", int'(busy), 0);

      cur_test = "t4_window1";
      set_cfg(0, 0, 0, 0, 1, 0, 0);
      push(9); push(4);
      beat(1, 9, 0, 0, 0, 1, 0, 0, 0, 0);
      beat(1, 4, 0, 0, 0, 1, 0, 0, 0, 0);
      idle(12);

      // Narrowing of out-of-range results.
      cur_test = "t5_narrow";
      set_cfg(0, 0, 0, 0, 0, 0, 0);
`ifdef XYOLO_SAT_EN
      push(32767); push(-32768);
`else
      push(-25536); push(25536);
`endif
      beat(1, 200, 0, 0, 0, 200, 0, 0, 0, 0);
      beat(1, 200, 0, 0, 0, -200, 0, 0, 0, 0);
      idle(12);

      // Reset mid-product discards it; a beat during reset is ignored.
      cur_test = "t6_reset";
      beat(0, 1, 2, 3, 4, 5, 6, 7, 8, 0);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; in_last = 1'b1;
      in_pixel = {4{16'd100}}; in_weight = {4{16'd100}};
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      check("t6_busy_after_rst", int'(busy), 0);
      check("t6_out_valid_after_rst", int'(out_valid), 0);
      idle(10);
      push(70);
      beat(1, 1, 2, 3, 4, 5, 6, 7, 8, 0);
      idle(12);

      cur_test = "end";
      check("exp_q_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
